// File: rtl/stripe_scheduler.sv
// stripe_scheduler: sequences the DLL byte stream onto the x4 byte striper.
// One symbol leaves per clock with its lane, K flag and broadcast flag.
// Packets start on lane 0 and are padded with IDL to a 4-lane boundary.
// Optional COM+SKP ordered-set insertion is built when STRIPE_SKP_INSERT_EN
// is defined; without it BCAST and SKP_ACTIVE stay 0.
module stripe_scheduler #(
  parameter int         SKP_INTERVAL = 1180,
  parameter int         SKP_LEN      = 3,
  parameter logic [7:0] COM          = 8'hbc,
  parameter logic [7:0] SKP          = 8'h1c,
  parameter logic [7:0] IDL          = 8'h7c,
  parameter logic [7:0] FTS          = 8'h3c,
  parameter logic [7:0] EDB          = 8'hfe
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       IN_VALID,
  input  logic [7:0] IN_DATA,
  input  logic       IN_K,
  input  logic       IN_LAST,
  output logic       IN_READY,
  output logic [7:0] D,
  output logic       DK,
  output logic [1:0] LANE_SEL,
  output logic       D_VALID,
  output logic       BCAST,
  output logic       GROUP_END,
  output logic       SKP_ACTIVE,
  output logic       ERROR_DLL
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_SKP_SYM
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] lane_q, lane_d;
  logic [7:0] d_q, d_d;
  logic       dk_q, dk_d;
  logic [1:0] lane_sel_q, lane_sel_d;
  logic       d_valid_q, d_valid_d;
  logic       bcast_q, bcast_d;
  logic       group_end_q, group_end_d;
  logic       skp_active_q, skp_active_d;
  logic       error_q, error_d;

  logic       skp_pending;
  logic       accept;
  logic       lane_emit;
  logic [7:0] sym;
  logic       sym_k;
  logic       byte_bad;
  logic [7:0] byte_sym;
  logic       byte_k;

`ifdef STRIPE_SKP_INSERT_EN
  logic [15:0] skp_cnt_q, skp_cnt_d;
  logic        skp_pending_q, skp_pending_d;
  logic [2:0]  skp_left_q, skp_left_d;

  assign skp_pending = skp_pending_q;
`else
  // Interval and length only matter when ordered sets are inserted; within
  // their legal ranges this expression is constant 0.
  assign skp_pending = (SKP_INTERVAL == 0) && (SKP_LEN == 0);
`endif

  // DLL K-codes that collide with link-layer control symbols
  function automatic logic is_reserved(input logic k, input logic [7:0] b);
    return k && ((b == COM) || (b == SKP) || (b == IDL) || (b == FTS));
  endfunction

  // Ready depends only on state, lane and pending SKP so the DLL never loops
  // its valid back into our ready.
  assign IN_READY = (state_q == ST_DATA) ||
                    ((state_q == ST_IDLE) && (lane_q == 2'd0) && !skp_pending);
  assign accept   = IN_VALID && IN_READY;

  // Next-state, emitted symbol and SKP bookkeeping
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    d_d          = 8'h00;
    dk_d         = 1'b0;
    lane_sel_d   = 2'd0;
    d_valid_d    = 1'b0;
    bcast_d      = 1'b0;
    group_end_d  = 1'b0;
    skp_active_d = 1'b0;
    error_d      = 1'b0;
    lane_emit    = 1'b0;
    sym          = IDL;
    sym_k        = 1'b1;
`ifdef STRIPE_SKP_INSERT_EN
    skp_cnt_d     = skp_cnt_q;
    skp_pending_d = skp_pending_q;
    skp_left_d    = skp_left_q;
`endif

    byte_bad = is_reserved(IN_K, IN_DATA);
    byte_sym = byte_bad ? EDB : IN_DATA;
    byte_k   = byte_bad | IN_K;

    case (state_q)
      ST_OFF: begin
        lane_d = 2'd0;
        if (EN) state_d = ST_IDLE;
      end
      ST_IDLE: begin
`ifdef STRIPE_SKP_INSERT_EN
        // The ordered set takes the lane-0 slot; COM goes out on this edge.
        if ((lane_q == 2'd0) && skp_pending_q) begin
          d_valid_d     = 1'b1;
          d_d           = COM;
          dk_d          = 1'b1;
          bcast_d       = 1'b1;
          group_end_d   = 1'b1;
          skp_active_d  = 1'b1;
          skp_pending_d = 1'b0;
          skp_left_d    = 3'(SKP_LEN);
          state_d       = ST_SKP_SYM;
        end else
`endif
        begin
          lane_emit = 1'b1;
          if (accept) begin
            sym     = byte_sym;
            sym_k   = byte_k;
            error_d = byte_bad;
            if (!IN_LAST)             state_d = ST_DATA;
            else if (lane_q == 2'd3)  state_d = ST_IDLE;
            else                      state_d = ST_PAD;
          end
        end
      end
      ST_DATA: begin
        // Missing bytes mid-packet become IDL filler on the current lane.
        lane_emit = 1'b1;
        if (accept) begin
          sym     = byte_sym;
          sym_k   = byte_k;
          error_d = byte_bad;
          if (IN_LAST) state_d = (lane_q == 2'd3) ? ST_IDLE : ST_PAD;
        end
      end
      ST_PAD: begin
        lane_emit = 1'b1;
        if (lane_q == 2'd3) state_d = ST_IDLE;
      end
`ifdef STRIPE_SKP_INSERT_EN
      ST_SKP_SYM: begin
        d_valid_d    = 1'b1;
        d_d          = SKP;
        dk_d         = 1'b1;
        bcast_d      = 1'b1;
        group_end_d  = 1'b1;
        skp_active_d = 1'b1;
        skp_left_d   = skp_left_q - 3'd1;
        if (skp_left_q == 3'd1) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_OFF;
        lane_d  = 2'd0;
      end
    endcase

    if (lane_emit) begin
      d_valid_d   = 1'b1;
      d_d         = sym;
      dk_d        = sym_k;
      lane_sel_d  = lane_q;
      group_end_d = (lane_q == 2'd3);
      lane_d      = lane_q + 2'd1;
    end

`ifdef STRIPE_SKP_INSERT_EN
    // A request landing while one is pending collapses into it.
    if (state_q != ST_OFF) begin
      if (skp_cnt_q == 16'(SKP_INTERVAL - 1)) begin
        skp_cnt_d     = 16'd0;
        skp_pending_d = 1'b1;
      end else begin
        skp_cnt_d = skp_cnt_q + 16'd1;
      end
    end
`endif

    // Link disable wins over everything and abandons any partial packet.
    if (!EN) begin
      state_d      = ST_OFF;
      lane_d       = 2'd0;
      d_d          = 8'h00;
      dk_d         = 1'b0;
      lane_sel_d   = 2'd0;
      d_valid_d    = 1'b0;
      bcast_d      = 1'b0;
      group_end_d  = 1'b0;
      skp_active_d = 1'b0;
      error_d      = 1'b0;
`ifdef STRIPE_SKP_INSERT_EN
      skp_cnt_d     = 16'd0;
      skp_pending_d = 1'b0;
      skp_left_d    = 3'd0;
`endif
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_OFF;
      lane_q       <= 2'd0;
      d_q          <= 8'h00;
      dk_q         <= 1'b0;
      lane_sel_q   <= 2'd0;
      d_valid_q    <= 1'b0;
      bcast_q      <= 1'b0;
      group_end_q  <= 1'b0;
      skp_active_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef STRIPE_SKP_INSERT_EN
      skp_cnt_q     <= 16'd0;
      skp_pending_q <= 1'b0;
      skp_left_q    <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      d_q          <= d_d;
      dk_q         <= dk_d;
      lane_sel_q   <= lane_sel_d;
      d_valid_q    <= d_valid_d;
      bcast_q      <= bcast_d;
      group_end_q  <= group_end_d;
      skp_active_q <= skp_active_d;
      error_q      <= error_d;
`ifdef STRIPE_SKP_INSERT_EN
      skp_cnt_q     <= skp_cnt_d;
      skp_pending_q <= skp_pending_d;
      skp_left_q    <= skp_left_d;
`endif
    end
  end

  assign D          = d_q;
  assign DK         = dk_q;
  assign LANE_SEL   = lane_sel_q;
  assign D_VALID    = d_valid_q;
  assign BCAST      = bcast_q;
  assign GROUP_END  = group_end_q;
  assign SKP_ACTIVE = skp_active_q;
  assign ERROR_DLL  = error_q;

endmodule

// File: tb/tb_stripe_scheduler.sv
// Bench for stripe_scheduler: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a queue-based model
// of the output symbol stream. Honours STRIPE_SKP_INSERT_EN like the DUT.
module tb_stripe_scheduler;

  localparam int SKP_INTERVAL = 16;
  localparam int SKP_LEN      = 3;
`ifdef STRIPE_SKP_INSERT_EN
  localparam bit SKP_ON = 1'b1;
`else
  localparam bit SKP_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET, EN, IN_VALID, IN_K, IN_LAST;
  logic [7:0] IN_DATA;
  logic       IN_READY, DK, D_VALID, BCAST, GROUP_END, SKP_ACTIVE, ERROR_DLL;
  logic [7:0] D;
  logic [1:0] LANE_SEL;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  stripe_scheduler #(.SKP_INTERVAL(SKP_INTERVAL), .SKP_LEN(SKP_LEN)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_K(IN_K), .IN_LAST(IN_LAST), .IN_READY(IN_READY), .D(D), .DK(DK),
    .LANE_SEL(LANE_SEL), .D_VALID(D_VALID), .BCAST(BCAST), .GROUP_END(GROUP_END),
    .SKP_ACTIVE(SKP_ACTIVE), .ERROR_DLL(ERROR_DLL)
  );

  // ---------------- reference model: link as a stream of symbols ----------
  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       b;
  } sym_t;

  sym_t q[$];          // symbols already owed to the link (pad, ordered set)
  bit   m_on;
  int   m_lane;
  bit   m_in_pkt;
  bit   m_pending;
  int   m_cnt;
  logic [7:0] e_d;
  logic e_dk, e_valid, e_bcast, e_gend, e_skpa, e_err, e_ready;
  logic [1:0] e_lane;

  function automatic bit model_ready();
    return m_on && (q.size() == 0) && (m_in_pkt || (m_lane == 0 && !m_pending));
  endfunction

  function automatic void put(input logic [7:0] d, input logic k, input logic b);
    e_valid = 1'b1; e_d = d; e_dk = k; e_bcast = b;
    if (b) begin
      e_lane = 2'd0; e_gend = 1'b1; e_skpa = 1'b1;
    end else begin
      e_lane = 2'(m_lane); e_gend = (m_lane == 3); e_skpa = 1'b0;
      m_lane = (m_lane + 1) % 4;
    end
  endfunction

  function automatic void take_byte();
    if (IN_K && (IN_DATA inside {8'hbc, 8'h1c, 8'h7c, 8'h3c})) begin
      put(8'hfe, 1'b1, 1'b0);
      e_err = 1'b1;
    end else begin
      put(IN_DATA, IN_K, 1'b0);
    end
    if (IN_LAST) begin
      m_in_pkt = 1'b0;
      for (int i = 0; i < (4 - m_lane) % 4; i++) q.push_back('{8'h7c, 1'b1, 1'b0});
    end else begin
      m_in_pkt = 1'b1;
    end
  endfunction

  always @(posedge CLK) begin : model
    bit rdy;
    rdy = model_ready();
    e_d = 8'h00; e_dk = 0; e_lane = 0; e_valid = 0; e_bcast = 0; e_gend = 0;
    e_skpa = 0; e_err = 0;
    if (RESET || !EN) begin
      m_on = 0; m_lane = 0; m_in_pkt = 0; m_pending = 0; m_cnt = 0; q.delete();
    end else if (!m_on) begin
      m_on = 1;
    end else begin
      if (q.size() > 0) begin
        sym_t s;
        s = q.pop_front();
        put(s.d, s.k, s.b);
      end else if (m_in_pkt) begin
        if (IN_VALID && rdy) take_byte();
        else put(8'h7c, 1'b1, 1'b0);
      end else if (m_lane == 0 && m_pending) begin
        put(8'hbc, 1'b1, 1'b1);
        m_pending = 0;
        for (int i = 0; i < SKP_LEN; i++) q.push_back('{8'h1c, 1'b1, 1'b1});
      end else if (IN_VALID && rdy) begin
        take_byte();
      end else begin
        put(8'h7c, 1'b1, 1'b0);
      end
      if (SKP_ON) begin
        m_cnt++;
        if (m_cnt == SKP_INTERVAL) begin
          m_cnt = 0;
          m_pending = 1;
        end
      end
    end
    e_ready = model_ready();
  end

  // ---------------- checking helpers --------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock, then compare every output against the model.
  task automatic cyc();
    @(posedge CLK);
    #1;
    chk("stream", {D, DK, LANE_SEL, D_VALID, BCAST, GROUP_END, SKP_ACTIVE, ERROR_DLL, IN_READY},
        {e_d, e_dk, e_lane, e_valid, e_bcast, e_gend, e_skpa, e_err, e_ready});
  endtask

  task automatic reset_link();
    RESET = 1'b1; EN = 1'($urandom_range(0, 1)); IN_VALID = 1'($urandom_range(0, 1));
    IN_DATA = 8'($urandom); IN_K = 1'($urandom_range(0, 1)); IN_LAST = 1'($urandom_range(0, 1));
    cyc();
    cyc();
    RESET = 1'b0; EN = 1'b1; IN_VALID = 1'b0; IN_K = 1'b0; IN_LAST = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!IN_READY && n < 20) begin cyc(); n++; end
    if (n == 20) chk("ready_timeout", 0, 1);
  endtask

  // Present one byte, hold it until accepted; returns cycles spent waiting.
  task automatic send_byte(input logic [7:0] d, input logic k, input logic last, output int waited);
    IN_VALID = 1'b1; IN_DATA = d; IN_K = k; IN_LAST = last;
    waited = 0;
    while (!IN_READY && waited < 40) begin cyc(); waited++; end
    if (waited == 40) chk("accept_timeout", 0, 1);
    cyc();
    IN_VALID = 1'b0; IN_K = 1'b0; IN_LAST = 1'b0;
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    int w;
    int pkt_left;
    bit acc;

    RESET = 1'b1; EN = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'h55; IN_K = 1'b0; IN_LAST = 1'b0;

    // Reset with random inputs: everything quiet.
    reset_link();
    chk("reset_outputs", {D, DK, LANE_SEL, D_VALID, BCAST, GROUP_END, SKP_ACTIVE, ERROR_DLL}, 0);
    chk("reset_ready", IN_READY, 0);
    cyc();
    chk("enable_edge_valid", D_VALID, 0);
    cyc();
    chk("first_idl", {D, DK, D_VALID, LANE_SEL}, {8'h7c, 1'b1, 1'b1, 2'd0});

    // 6-byte packet, lane-0 aligned, padded to lane 3.
    wait_ready();
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i), 1'b0, i == 6, w);
      chk($sformatf("pkt6_byte%0d", i), {D, LANE_SEL, GROUP_END}, {8'(i), 2'((i - 1) % 4), i == 4});
    end
    chk("pkt6_ready_in_pad", IN_READY, 0);
    cyc();
    chk("pkt6_pad_lane2", {D, DK, LANE_SEL, GROUP_END, IN_READY}, {8'h7c, 1'b1, 2'd2, 1'b0, 1'b0});
    cyc();
    chk("pkt6_pad_lane3", {D, DK, LANE_SEL, GROUP_END}, {8'h7c, 1'b1, 2'd3, 1'b1});
    chk("pkt6_ready_after", IN_READY, 1);

    // Reserved K-code inside a packet becomes EDB; legal K passes.
    reset_link();
    cyc(); cyc();
    wait_ready();
    send_byte(8'ha0, 1'b0, 1'b0, w);
    send_byte(8'h1c, 1'b1, 1'b0, w);
    chk("edb_sub", {D, DK, LANE_SEL, ERROR_DLL}, {8'hfe, 1'b1, 2'd1, 1'b1});
    send_byte(8'ha2, 1'b0, 1'b0, w);
    chk("edb_after", {D, DK, ERROR_DLL}, {8'ha2, 1'b0, 1'b0});
    send_byte(8'hf7, 1'b1, 1'b1, w);
    chk("legal_k", {D, DK, LANE_SEL, GROUP_END, ERROR_DLL}, {8'hf7, 1'b1, 2'd3, 1'b1, 1'b0});
    chk("lane3_last_no_pad", IN_READY, 1);

    // EN dropped mid-packet: link goes quiet, restart without pad.
    reset_link();
    cyc(); cyc();
    wait_ready();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h31 + i), 1'b0, 1'b0, w);
    EN = 1'b0;
    cyc();
    chk("en_drop", {D_VALID, IN_READY}, 0);
    cyc();
    EN = 1'b1;
    cyc();
    chk("en_raise_edge", D_VALID, 0);
    cyc();
    chk("en_restart", {D, DK, D_VALID, LANE_SEL}, {8'h7c, 1'b1, 1'b1, 2'd0});

`ifdef STRIPE_SKP_INSERT_EN
    // Idle link: first request at edge 17 after enable, COM on edge 18.
    reset_link();
    w = 0;
    for (int e = 1; e <= 40 && w == 0; e++) begin
      cyc();
      if (BCAST) w = e;
    end
    chk("skp_com_edge", w, 18);
    chk("skp_com", {D, DK, LANE_SEL, GROUP_END, SKP_ACTIVE}, {8'hbc, 1'b1, 2'd0, 1'b1, 1'b1});
    for (int i = 0; i < SKP_LEN; i++) begin
      cyc();
      chk($sformatf("skp_sym%0d", i), {D, DK, BCAST, GROUP_END, SKP_ACTIVE}, {8'h1c, 1'b1, 1'b1, 1'b1, 1'b1});
    end
    cyc();
    chk("skp_done", {D, BCAST, SKP_ACTIVE, LANE_SEL}, {8'h7c, 1'b0, 1'b0, 2'd0});

    // 12-byte packet spanning the request: bytes contiguous, COM right after.
    reset_link();
    cyc(); cyc();
    wait_ready();
    for (int i = 0; i < 12; i++) begin
      send_byte(8'(8'h40 + i), 1'b0, i == 11, w);
      chk($sformatf("span_byte%0d", i), {D, BCAST, 8'(w)}, {8'(8'h40 + i), 1'b0, 8'd0});
    end
    cyc();
    chk("span_com", {D, BCAST, SKP_ACTIVE}, {8'hbc, 1'b1, 1'b1});
`endif

    // Randomized traffic with gaps, K-codes, link drops and resets.
    reset_link();
    pkt_left = 0;
    for (int c = 0; c < 3000; c++) begin
      RESET = ($urandom_range(0, 299) == 0);
      EN    = ($urandom_range(0, 99) != 0);
      if (pkt_left == 0 && $urandom_range(0, 3) == 0) pkt_left = $urandom_range(1, 12);
      IN_VALID = (pkt_left > 0) && ($urandom_range(0, 4) != 0);
      IN_K     = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 6))
        0: IN_DATA = 8'hbc;
        1: IN_DATA = 8'h1c;
        2: IN_DATA = 8'h7c;
        3: IN_DATA = 8'h3c;
        4: IN_DATA = 8'hf7;
        default: IN_DATA = 8'($urandom);
      endcase
      IN_LAST = (pkt_left == 1);
      acc = IN_VALID && IN_READY && EN && !RESET;
      cyc();
      if (RESET || !EN) pkt_left = 0;
      else if (acc) pkt_left--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
